alu_stream: RTL and testbench
=============================

// Module: alu_stream
// PURPOSE
//  Parametrised, registered successor of the 6-bit combinational ALU. It keeps the same
//  8-function opcode map. It adds a valid/ready stream handshake, status flags, a sticky
//  overflow bit, and an accumulator that can replace operand A for chained calculations.
//  It sits between an operand source (a sequencer or register file) and a result consumer.
// PARAMETERS
//  WIDTH      6  operand/result width in bits, two's complement, >= 2
//  SIGNED_CMP 1  1: fxn 100 compares signed; 0: compares unsigned
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/fxn presented this cycle
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  fxn        in   3      function select (map below)
//  use_acc    in   1      1: substitute acc register for A in this operation
//  clr_sticky in   1      clear ovf_sticky
//  out_valid  out  1      X/flags hold a result not yet consumed
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  X          out  WIDTH  result
//  zero       out  1      X == 0
//  neg        out  1      X[WIDTH-1]
//  carry      out  1      carry (add) / borrow (sub), else 0
//  ovf        out  1      signed overflow of this result
//  ovf_sticky out  1      OR of ovf over all accepted ops since last clear
// BEHAVIOUR
//  Reset (async, immediate): out_valid=0, X=0, zero=1, neg=0, carry=0, ovf=0,
//   ovf_sticky=0, acc=0. in_ready is combinational and is 1 after reset.
//  Opa = use_acc ? acc : A. fxn: 000 X=Opa; 001 X=B; 010 X=-Opa; 011 X=-B;
//   100 X={0..,Opa<B}; 101 X=~(Opa^B); 110 X=Opa+B; 111 X=Opa-B. All results mod 2^WIDTH.
//  Flags:
//   - carry = bit WIDTH of the unsigned add (110), or borrow = (Opa<B unsigned) for 111.
//   - ovf = signed overflow for 110/111. For 010/011, ovf=1 iff the operand is the most
//     negative value (10..0).
//   - carry=ovf=0 for all other functions.
//  Handshake: single output register, latency 1.
//   - in_ready = !out_valid | out_ready.
//   - On accept, X/flags/out_valid=1 load at the next edge.
//   - Output drained without a new accept: out_valid->0 at the edge; X and flags hold.
//   - Accept and drain in the same cycle: back-to-back, one result per cycle, no bubble.
//   - out_valid=1 & !out_ready: X/flags stable and in_ready=0; inputs are ignored.
//  acc: loads the new X on every accepted op (including when use_acc=1), so it always
//   equals the most recent result. It is not affected by draining the output.
//  ovf_sticky: set by an accepted op with ovf=1. clr_sticky alone clears it.
//   Set and clear in the same cycle: set wins (result 1).
//  Mid-operation reset forces the reset values regardless of handshake state; a pending
//   result is lost.
//  in_valid=0: nothing changes except an output drain.
// TESTING
//  1. WIDTH=6, fxn 110, A=6'd20, B=6'd15 -> 1 cycle later X=35, carry=0, ovf=1,
//     neg=1, ovf_sticky=1.
//  2. WIDTH=6, fxn 111, A=5, B=7 -> X=6'b111110, carry(borrow)=1, ovf=0, neg=1;
//     fxn 010, A=6'b100000 -> X=6'b100000, ovf=1.
//  3. Chain with out_ready=1: fxn 000 A=3; fxn 110 use_acc=1 B=4; fxn 110 use_acc=1 B=4
//     -> X = 3, 7, 11 on consecutive cycles, out_valid held high.
//  4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, X frozen,
//     input fxn/A/B ignored; out_ready->1 -> held result drains, next op accepted
//     the same cycle.
//  5. SIGNED_CMP=1, fxn 100, A=-1, B=1 -> X=1; SIGNED_CMP=0, same inputs -> X=0, zero=1;
//     fxn 101, A=6'b101010, B=6'b100101 -> X=6'b110000.
//  6. Reset asserted while out_valid=1 and ovf_sticky=1 -> all outputs return to reset
//     values asynchronously; clr_sticky with a simultaneous overflowing op -> ovf_sticky
//     stays 1.

Source files
------------

// File: rtl/alu_stream.sv
// Registered 8-function ALU with a valid/ready stream interface, status flags,
// a sticky overflow bit and an accumulator that can stand in for operand A.
module alu_stream #(
  parameter int unsigned WIDTH      = 6,
  parameter bit          SIGNED_CMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       fxn,
  input  logic             use_acc,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             ovf_sticky
);

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             lt;
  logic             accept;
  logic [WIDTH-1:0] res_x;
  logic             res_c;
  logic             res_v;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign opa      = use_acc ? acc_q : A;
  assign sum      = {1'b0, opa} + {1'b0, B};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff     = {1'b0, opa} - {1'b0, B};
  assign lt       = SIGNED_CMP ? ($signed(opa) < $signed(B)) : (opa < B);

  always_comb begin
    res_x = opa;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (fxn)
      3'b000: res_x = opa;
      3'b001: res_x = B;
      3'b010: begin
        res_x = -opa;
        res_v = (opa == MinNeg);
      end
      3'b011: begin
        res_x = -B;
        res_v = (B == MinNeg);
      end
      3'b100: res_x = {{(WIDTH-1){1'b0}}, lt};
      3'b101: res_x = ~(opa ^ B);
      3'b110: begin
        res_x = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (opa[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b111: begin
        res_x = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (opa[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      X          <= '0;
      zero       <= 1'b1;
      neg        <= 1'b0;
      carry      <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        X         <= res_x;
        zero      <= (res_x == '0);
        neg       <= res_x[WIDTH-1];
        carry     <= res_c;
        ovf       <= res_v;
        acc_q     <= res_x;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A simultaneous set beats the clear.
      if (accept && res_v) begin
        ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// Scoreboard bench for alu_stream: a signed-compare and an unsigned-compare instance
// share stimulus; an arithmetic reference model predicts each result.
module tb_alu_stream;
  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] x;
    logic z, n, c, v, st;
  } exp_t;

  logic clk, reset, in_valid, use_acc, clr_sticky, out_ready;
  logic [W-1:0] A, B;
  logic [2:0] fxn;
  logic in_ready_s, out_valid_s, zero_s, neg_s, carry_s, ovf_s, sticky_s;
  logic in_ready_u, out_valid_u, zero_u, neg_u, carry_u, ovf_u, sticky_u;
  logic [W-1:0] X_s, X_u;

  alu_stream #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .A(A), .B(B),
    .fxn(fxn), .use_acc(use_acc), .clr_sticky(clr_sticky), .out_valid(out_valid_s),
    .out_ready(out_ready), .X(X_s), .zero(zero_s), .neg(neg_s), .carry(carry_s),
    .ovf(ovf_s), .ovf_sticky(sticky_s)
  );

  alu_stream #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u), .A(A), .B(B),
    .fxn(fxn), .use_acc(use_acc), .clr_sticky(clr_sticky), .out_valid(out_valid_u),
    .out_ready(out_ready), .X(X_u), .zero(zero_u), .neg(neg_u), .carry(carry_u),
    .ovf(ovf_u), .ovf_sticky(sticky_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  exp_t q_s[$];
  exp_t q_u[$];
  int acc_s, acc_u;
  bit st_s, st_u;
  bit rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t compute(input int opa, input int b, input int f, input bit sc);
    int m, h, sa, sb, r;
    exp_t e;
    m = 1 << W;
    h = m / 2;
    sa = (opa >= h) ? opa - m : opa;
    sb = (b >= h) ? b - m : b;
    e = '0;
    r = 0;
    case (f)
      0: r = opa;
      1: r = b;
      2: begin r = (m - opa) % m; e.v = (opa == h); end
      3: begin r = (m - b) % m; e.v = (b == h); end
      4: r = sc ? int'(sa < sb) : int'(opa < b);
      5: r = (m - 1) - (opa ^ b);
      6: begin
        r = opa + b;
        e.c = (r >= m);
        e.v = (sa + sb >= h) || (sa + sb < -h);
        r = r % m;
      end
      default: begin
        r = opa - b;
        e.c = (opa < b);
        e.v = (sa - sb >= h) || (sa - sb < -h);
        r = (r + m) % m;
      end
    endcase
    e.x = r[W-1:0];
    e.z = (r == 0);
    e.n = (r >= h);
    return e;
  endfunction

  task automatic push_model(input int f, input int a, input int b, input bit ua, input bit clr);
    exp_t e;
    e = compute(ua ? acc_s : a, b, f, 1'b1);
    st_s = clr ? e.v : (st_s | e.v);
    e.st = st_s;
    acc_s = e.x;
    q_s.push_back(e);
    e = compute(ua ? acc_u : a, b, f, 1'b0);
    st_u = clr ? e.v : (st_u | e.v);
    e.st = st_u;
    acc_u = e.x;
    q_u.push_back(e);
  endtask

  // Starts and ends one time unit after a rising edge; waited = stall cycles.
  task automatic issue(input int f, input int a, input int b, input bit ua, input bit clr,
                       output int waited);
    bit ok;
    fxn = f[2:0]; A = a[W-1:0]; B = b[W-1:0]; use_acc = ua; clr_sticky = clr;
    in_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (in_ready_s) ok = 1'b1;
      else if (waited >= 200) begin
        n_checks++;
        $display("FAIL issue_timeout: in_ready stuck at 0 for %0d cycles", waited);
        break;
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    if (ok) push_model(f, a, b, ua, clr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr_sticky = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid_s && out_ready) begin
      if (q_s.size() == 0 || q_u.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: output presented with no expected result queued");
      end else begin
        check("out_signed", {X_s, zero_s, neg_s, carry_s, ovf_s, sticky_s}, q_s.pop_front());
        check("out_unsigned", {X_u, zero_u, neg_u, carry_u, ovf_u, sticky_u},
              q_u.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    reset = 1'b0; in_valid = 1'b0; use_acc = 1'b0; clr_sticky = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; fxn = '0;
    acc_s = 0; acc_u = 0; st_s = 1'b0; st_u = 1'b0; rand_done = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("reset_out_valid", out_valid_s, 0);
    check("reset_flags", {X_s, zero_s, neg_s, carry_s, ovf_s, sticky_s}, {6'd0, 5'b10000});
    check("reset_in_ready", in_ready_s, 1);
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;

    // Add with signed overflow.
    issue(6, 20, 15, 1'b0, 1'b0, w);
    check("add_x", X_s, 35);
    check("add_flags", {carry_s, ovf_s, neg_s, sticky_s}, 4'b0111);
    // Subtract with borrow, negate of the most negative value.
    issue(7, 5, 7, 1'b0, 1'b0, w);
    check("sub_x", X_s, 6'b111110);
    check("sub_flags", {carry_s, ovf_s, neg_s}, 3'b101);
    issue(2, 32, 0, 1'b0, 1'b0, w);
    check("neg_min", {X_s, ovf_s}, {6'b100000, 1'b1});
    // Compare in both signedness modes, XNOR.
    issue(4, 63, 1, 1'b0, 1'b0, w);
    check("slt_signed", X_s, 1);
    check("slt_unsigned", {X_u, zero_u}, {6'd0, 1'b1});
    issue(5, 6'b101010, 6'b100101, 1'b0, 1'b0, w);
    check("xnor", X_s, 6'b110000);

    // Accumulator chain, back to back.
    issue(0, 3, 0, 1'b0, 1'b0, w);
    check("chain0", {out_valid_s, X_s}, {1'b1, 6'd3});
    issue(6, 0, 4, 1'b1, 1'b0, w);
    check("chain1", {out_valid_s, X_s, 6'(w)}, {1'b1, 6'd7, 6'd0});
    issue(6, 0, 4, 1'b1, 1'b0, w);
    check("chain2", {out_valid_s, X_s, 6'(w)}, {1'b1, 6'd11, 6'd0});
    @(posedge clk); #1;

    // Backpressure: hold a result, junk inputs must be ignored.
    out_ready = 1'b0;
    issue(1, 0, 9, 1'b0, 1'b0, w);
    in_valid = 1'b1; fxn = 3'b011; A = 6'd17; B = 6'd33;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready_s, 0);
      check("bp_hold", {out_valid_s, X_s}, {1'b1, 6'd9});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(6, 1, 1, 1'b0, 1'b0, w);
    check("bp_release", {X_s, 6'(w)}, {6'd2, 6'd0});

    // Randomised traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          n = $urandom_range(0, 2);
          repeat (n) begin @(posedge clk); #1; end
          issue($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63),
                ($urandom_range(0, 1) == 1), 1'b0, w);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (q_s.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain_empty", q_s.size(), 0);
    @(posedge clk); #1;

    // Reset while holding an overflowing result.
    out_ready = 1'b0;
    issue(6, 20, 15, 1'b0, 1'b0, w);
    check("pre_reset", {out_valid_s, sticky_s}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("midreset_out", {out_valid_s, X_s, zero_s, neg_s, carry_s, ovf_s, sticky_s},
          {1'b0, 6'd0, 5'b10000});
    check("midreset_in_ready", in_ready_s, 1);
    q_s.delete(); q_u.delete();
    acc_s = 0; acc_u = 0; st_s = 1'b0; st_u = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    issue(6, 0, 5, 1'b1, 1'b0, w);
    check("acc_after_reset", X_s, 5);
    // Clear and overflow together: set wins.
    issue(6, 20, 15, 1'b0, 1'b1, w);
    check("clr_vs_set", sticky_s, 1);
    clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    check("clr_alone", sticky_s, 0);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", q_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
